// File: rtl/risa_cmd_issuer.sv
// Host-side command issuer: queues host commands, optionally locks core state, issues each command
// to the core, captures the state reply and returns it to the host. Optional macro: RISA_CMD_PERF_EN.
module risa_cmd_issuer #(
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 64,
  parameter int STATE_W = 32,
  parameter int QDEPTH  = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               host_cmd_valid_i,
  output logic               host_cmd_ready_o,
  input  logic [CMD_W-1:0]   host_cmd_op_i,
  input  logic [DATA_W-1:0]  host_cmd_data_i,
  input  logic               host_cmd_lock_i,
  output logic               host_rsp_valid_o,
  input  logic               host_rsp_ready_i,
  output logic [STATE_W-1:0] host_rsp_state_o,
  output logic [1:0]         host_rsp_status_o,
  output logic               core_cmd_valid_o,
  output logic [CMD_W-1:0]   core_cmd_op_o,
  output logic [DATA_W-1:0]  core_cmd_data_o,
  input  logic               core_cmd_ack_i,
  input  logic               core_state_valid_i,
  input  logic [STATE_W-1:0] core_state_i,
  input  logic               core_idle_i,
  output logic               state_lock_cmd_o,
  output logic [31:0]        perf_cmd_cnt_o,
  output logic [15:0]        perf_tmo_cnt_o,
  output logic [2:0]         dbg_state_o
);

  // Host handshakes: a transfer happens on any rising clk edge where valid and ready are both high;
  // valid holds its payload stable until that edge, ready may toggle freely.

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(TMO_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCK  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state;
  logic [CW-1:0] phase_cnt;

  logic [CMD_W-1:0]  fifo_op   [QDEPTH];
  logic [DATA_W-1:0] fifo_data [QDEPTH];
  logic              fifo_lock [QDEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt, fifo_cnt_nxt;
  logic              full_q;
  logic              push, pop;
  logic              tmo_hit, rsp_done;

  assign host_cmd_ready_o = !full_q;
  assign push = host_cmd_valid_i && !full_q;
  assign pop  = (state == S_IDLE) && (fifo_cnt != '0);
  assign dbg_state_o = state;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop)
      fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (!push && pop)
      fifo_cnt_nxt = fifo_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_nxt;
      full_q   <= (fifo_cnt_nxt == FIFO_FULL);
    end
  end

  // Payload storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_op[wr_ptr]   <= host_cmd_op_i;
      fifo_data[wr_ptr] <= host_cmd_data_i;
      fifo_lock[wr_ptr] <= host_cmd_lock_i;
    end
  end

  // A genuine core event in the final counted cycle wins over the timeout.
  always_comb begin
    tmo_hit = 1'b0;
    if (phase_cnt == TMO_LAST) begin
      unique case (state)
        S_LOCK:  tmo_hit = !core_idle_i;
        S_ISSUE: tmo_hit = !core_cmd_ack_i;
        S_WAIT:  tmo_hit = !core_state_valid_i;
        default: tmo_hit = 1'b0;
      endcase
    end
  end

  assign rsp_done = (state == S_RESP) && host_rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      phase_cnt         <= '0;
      core_cmd_valid_o  <= 1'b0;
      core_cmd_op_o     <= '0;
      core_cmd_data_o   <= '0;
      state_lock_cmd_o  <= 1'b0;
      host_rsp_valid_o  <= 1'b0;
      host_rsp_state_o  <= '0;
      host_rsp_status_o <= 2'b00;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          phase_cnt <= '0;
          if (pop) begin
            core_cmd_op_o   <= fifo_op[rd_ptr];
            core_cmd_data_o <= fifo_data[rd_ptr];
            if (fifo_lock[rd_ptr]) begin
              state            <= S_LOCK;
              state_lock_cmd_o <= 1'b1;
            end else begin
              state            <= S_ISSUE;
              core_cmd_valid_o <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (core_idle_i) begin
            state            <= S_ISSUE;
            core_cmd_valid_o <= 1'b1;
            phase_cnt        <= '0;
          end
        end
        S_ISSUE: begin
          if (core_cmd_ack_i) begin
            core_cmd_valid_o <= 1'b0;
            phase_cnt        <= '0;
            if (core_state_valid_i) begin
              state             <= S_RESP;
              host_rsp_valid_o  <= 1'b1;
              host_rsp_state_o  <= core_state_i;
              host_rsp_status_o <= 2'b00;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (core_state_valid_i) begin
            state             <= S_RESP;
            phase_cnt         <= '0;
            host_rsp_valid_o  <= 1'b1;
            host_rsp_state_o  <= core_state_i;
            host_rsp_status_o <= 2'b00;
          end
        end
        S_RESP: begin
          phase_cnt <= '0;
          if (host_rsp_ready_i) begin
            state            <= S_IDLE;
            host_rsp_valid_o <= 1'b0;
            state_lock_cmd_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (tmo_hit) begin
        state             <= S_RESP;
        phase_cnt         <= '0;
        core_cmd_valid_o  <= 1'b0;
        host_rsp_valid_o  <= 1'b1;
        host_rsp_state_o  <= '0;
        host_rsp_status_o <= 2'b01;
      end
    end
  end

`ifdef RISA_CMD_PERF_EN
  logic [31:0] cmd_cnt_q;
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (rsp_done && (host_rsp_status_o == 2'b00) && (cmd_cnt_q != '1))
        cmd_cnt_q <= cmd_cnt_q + 1'b1;
      if (tmo_hit && (tmo_cnt_q != '1))
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign perf_cmd_cnt_o = cmd_cnt_q;
  assign perf_tmo_cnt_o = tmo_cnt_q;
`else
  logic unused_perf;
  assign unused_perf    = rsp_done;
  assign perf_cmd_cnt_o = '0;
  assign perf_tmo_cnt_o = '0;
`endif

endmodule

// File: tb/tb_risa_cmd_issuer.sv
// Bench for risa_cmd_issuer: directed host commands, a scripted core model, and response and
// command scoreboards checked by independent monitors.
module tb_risa_cmd_issuer;
  localparam int CMD_W   = 8;
  localparam int DATA_W  = 64;
  localparam int STATE_W = 32;
  localparam int QDEPTH  = 4;
  localparam int TMO_CYC = 16;
  localparam int RSP_W   = STATE_W + 2;
  localparam int CQ_W    = CMD_W + DATA_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               host_cmd_valid = 1'b0;
  logic               host_cmd_ready_o;
  logic [CMD_W-1:0]   host_cmd_op = '0;
  logic [DATA_W-1:0]  host_cmd_data = '0;
  logic               host_cmd_lock = 1'b0;
  logic               host_rsp_valid_o;
  logic               host_rsp_ready = 1'b1;
  logic [STATE_W-1:0] host_rsp_state_o;
  logic [1:0]         host_rsp_status_o;
  logic               core_cmd_valid_o;
  logic [CMD_W-1:0]   core_cmd_op_o;
  logic [DATA_W-1:0]  core_cmd_data_o;
  logic               core_cmd_ack = 1'b0;
  logic               core_state_valid = 1'b0;
  logic [STATE_W-1:0] core_state = '0;
  logic               core_idle = 1'b1;
  logic               state_lock_cmd_o;
  logic [31:0]        perf_cmd_cnt_o;
  logic [15:0]        perf_tmo_cnt_o;
  logic [2:0]         dbg_state_o;

  risa_cmd_issuer #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .STATE_W(STATE_W), .QDEPTH(QDEPTH), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_cmd_valid_i(host_cmd_valid), .host_cmd_ready_o(host_cmd_ready_o),
    .host_cmd_op_i(host_cmd_op), .host_cmd_data_i(host_cmd_data), .host_cmd_lock_i(host_cmd_lock),
    .host_rsp_valid_o(host_rsp_valid_o), .host_rsp_ready_i(host_rsp_ready),
    .host_rsp_state_o(host_rsp_state_o), .host_rsp_status_o(host_rsp_status_o),
    .core_cmd_valid_o(core_cmd_valid_o), .core_cmd_op_o(core_cmd_op_o), .core_cmd_data_o(core_cmd_data_o),
    .core_cmd_ack_i(core_cmd_ack), .core_state_valid_i(core_state_valid), .core_state_i(core_state),
    .core_idle_i(core_idle), .state_lock_cmd_o(state_lock_cmd_o),
    .perf_cmd_cnt_o(perf_cmd_cnt_o), .perf_tmo_cnt_o(perf_tmo_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [RSP_W-1:0] exp_q[$];
  logic [CQ_W-1:0]  cmd_q[$];
  logic [RSP_W-1:0] rsp_e;
  logic [CQ_W-1:0]  cmd_e;
  int ok_cnt = 0;
  logic lock_hi_seen = 1'b0;

  // core model knobs
  logic core_auto = 1'b0;
  int ack_dly = 1;
  int st_dly = 1;
  logic reply_fixed_en = 1'b0;
  logic [STATE_W-1:0] reply_fixed = '0;
  logic [STATE_W-1:0] reply;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && host_rsp_valid_o && host_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got 0x%0h expected no response", {host_rsp_state_o, host_rsp_status_o});
      end else begin
        rsp_e = exp_q.pop_front();
        check("rsp", 80'({host_rsp_state_o, host_rsp_status_o}), 80'(rsp_e));
        if (rsp_e[1:0] == 2'b00) ok_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && core_cmd_valid_o && core_cmd_ack) begin
      if (cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: got 0x%0h expected no command", {core_cmd_op_o, core_cmd_data_o});
      end else begin
        cmd_e = cmd_q.pop_front();
        check("cmd_order", 80'({core_cmd_op_o, core_cmd_data_o}), 80'(cmd_e));
      end
    end
  end

  always @(negedge clk) if (state_lock_cmd_o) lock_hi_seen = 1'b1;

  // ---------------- core model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (core_auto && core_cmd_valid_o && !rst) begin
        reply = reply_fixed_en ? reply_fixed : {24'hC0DE00, core_cmd_op_o};
        repeat (ack_dly) @(posedge clk);
        #1;
        core_cmd_ack = 1'b1;
        if (st_dly == 0) begin
          core_state_valid = 1'b1;
          core_state = reply;
        end
        @(posedge clk); #1;
        core_cmd_ack = 1'b0;
        core_state_valid = 1'b0;
        if (st_dly > 0) begin
          for (int k = 1; k < st_dly; k++) begin @(posedge clk); #1; end
          core_state_valid = 1'b1;
          core_state = reply;
          @(posedge clk); #1;
          core_state_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [63:0] data, input logic lk, input bit exp_issue);
    int n = 0;
    host_cmd_valid = 1'b1;
    host_cmd_op = op;
    host_cmd_data = data;
    host_cmd_lock = lk;
    @(negedge clk);
    while (!host_cmd_ready_o && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!host_cmd_ready_o) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready stayed 0, required 1 (op 0x%0h)", op);
    end else if (exp_issue) begin
      cmd_q.push_back({op, data});
    end
    tick();
    host_cmd_valid = 1'b0;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return host_rsp_valid_o;
      1: return core_cmd_valid_o;
      default: return state_lock_cmd_o;
    endcase
  endfunction

  // ends on the negedge where the selected output is first seen high
  task automatic wait_for(input string name, input int w, input int limit);
    int n = 0;
    @(negedge clk);
    while (!sig(w) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'(sig(w)), 80'(1));
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'(exp_q.size()), 80'(0));
  endtask

  // ---------------- directed sequence ----------------
  int t0, t1;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 80'(host_cmd_ready_o), 80'(1));
    check("reset_outs_zero", 80'(|{host_rsp_valid_o, host_rsp_state_o, host_rsp_status_o, core_cmd_valid_o,
          core_cmd_op_o, core_cmd_data_o, state_lock_cmd_o, perf_cmd_cnt_o, perf_tmo_cnt_o}), 80'(0));
    check("reset_fsm_idle", 80'(dbg_state_o), 80'(0));
    tick();

    // T1: unlocked command, ack cycle 2, state cycle 4
    core_auto = 1'b1; ack_dly = 2; st_dly = 2;
    reply_fixed_en = 1'b1; reply_fixed = 32'hDEAD0001;
    lock_hi_seen = 1'b0;
    exp_q.push_back({32'hDEAD0001, 2'b00});
    push_cmd(8'h12, 64'hA5A5, 1'b0, 1'b1);
    wait_for("t1_rsp_valid", 0, 50);
    tick();
    @(negedge clk);
    check("t1_lock_never", 80'(lock_hi_seen), 80'(0));
    check("t1_rsp_dropped", 80'(host_rsp_valid_o), 80'(0));
    tick();

    // T2: locked command, core busy for 10 cycles
    core_idle = 1'b0; ack_dly = 1; st_dly = 1; reply_fixed = 32'h12345678;
    exp_q.push_back({32'h12345678, 2'b00});
    push_cmd(8'h21, 64'h1111, 1'b1, 1'b1);
    wait_for("t2_lock_high", 2, 20);
    for (int i = 0; i < 10; i++) begin
      check("t2_no_issue_while_busy", 80'({core_cmd_valid_o, state_lock_cmd_o}), 80'(2'b01));
      tick();
      @(negedge clk);
    end
    tick();
    core_idle = 1'b1;
    @(negedge clk);
    check("t2_no_issue_idle_cycle", 80'(core_cmd_valid_o), 80'(0));
    tick();
    @(negedge clk);
    check("t2_issue_after_idle", 80'(core_cmd_valid_o), 80'(1));
    wait_for("t2_rsp_valid", 0, 20);
    check("t2_lock_in_resp", 80'(state_lock_cmd_o), 80'(1));
    tick();
    @(negedge clk);
    check("t2_lock_dropped", 80'(state_lock_cmd_o), 80'(0));
    tick();

    // T3: fill the FIFO behind a response the host is holding off
    reply_fixed_en = 1'b0;
    host_rsp_ready = 1'b0;
    exp_q.push_back({32'hC0DE0030, 2'b00});
    push_cmd(8'h30, 64'h3000, 1'b0, 1'b1);
    wait_for("t3_blocker_rsp", 0, 20);
    tick();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({24'hC0DE00, 8'(8'h30 + i), 2'b00});
      push_cmd(8'(8'h30 + i), 64'(64'h3000 + i), 1'b0, 1'b1);
    end
    @(negedge clk);
    check("t3_full_not_ready", 80'(host_cmd_ready_o), 80'(0));
    exp_q.push_back({32'hC0DE0035, 2'b00});
    fork
      push_cmd(8'h35, 64'h3005, 1'b0, 1'b1);
      begin
        repeat (3) tick();
        host_rsp_ready = 1'b1;
      end
    join
    wait_drain("t3_all_rsp", 300);
    check("t3_cmds_issued", 80'(cmd_q.size()), 80'(0));
    tick();

    // T4: core never acks
    core_auto = 1'b0;
    host_rsp_ready = 1'b0;
    exp_q.push_back({32'h0, 2'b01});
    push_cmd(8'h44, 64'hBEEF, 1'b0, 1'b0);
    wait_for("t4_issue", 1, 20);
    t0 = cyc;
    wait_for("t4_rsp_valid", 0, 50);
    t1 = cyc;
    check("t4_tmo_cycles", 80'(t1 - t0), 80'(16));
    check("t4_valid_dropped", 80'(core_cmd_valid_o), 80'(0));
    tick();
    core_cmd_ack = 1'b1; core_state_valid = 1'b1; core_state = 32'hFFFF_FFFF;
    tick();
    core_cmd_ack = 1'b0; core_state_valid = 1'b0;
    @(negedge clk);
    check("t4_late_ignored", 80'({host_rsp_state_o, host_rsp_status_o}), 80'({32'h0, 2'b01}));
    tick();
    host_rsp_ready = 1'b1;
    wait_drain("t4_rsp", 20);
    tick();

    // T5: ack and state together, host stalls 3 cycles
    core_auto = 1'b1; ack_dly = 1; st_dly = 0;
    reply_fixed_en = 1'b1; reply_fixed = 32'h5A5A0005;
    host_rsp_ready = 1'b0;
    exp_q.push_back({32'h5A5A0005, 2'b00});
    push_cmd(8'h55, 64'h5555, 1'b0, 1'b1);
    wait_for("t5_rsp_valid", 0, 20);
    for (int i = 0; i < 3; i++) begin
      check("t5_rsp_stable", 80'({host_rsp_valid_o, host_rsp_state_o, host_rsp_status_o}),
            80'({1'b1, 32'h5A5A0005, 2'b00}));
      tick();
      @(negedge clk);
    end
    tick();
    host_rsp_ready = 1'b1;
    wait_drain("t5_rsp", 20);
    tick();
    @(negedge clk);
    check("t5_single_rsp", 80'({host_rsp_valid_o, core_cmd_valid_o}), 80'(0));

`ifdef RISA_CMD_PERF_EN
    check("perf_cmd_cnt", 80'(perf_cmd_cnt_o), 80'(ok_cnt));
    check("perf_tmo_cnt", 80'(perf_tmo_cnt_o), 80'(1));
`else
    check("perf_cmd_tied", 80'(perf_cmd_cnt_o), 80'(0));
    check("perf_tmo_tied", 80'(perf_tmo_cnt_o), 80'(0));
`endif
    tick();

    // T6: reset while waiting for state with lock held and a command queued
    core_auto = 1'b0;
    push_cmd(8'h66, 64'h6666, 1'b1, 1'b1);
    wait_for("t6_issue", 1, 20);
    tick();
    core_cmd_ack = 1'b1;
    tick();
    core_cmd_ack = 1'b0;
    push_cmd(8'h67, 64'h6767, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_lock_in_wait", 80'(state_lock_cmd_o), 80'(1));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rst_ready", 80'(host_cmd_ready_o), 80'(1));
    check("t6_rst_outs_zero", 80'(|{host_rsp_valid_o, host_rsp_state_o, host_rsp_status_o, core_cmd_valid_o,
          core_cmd_op_o, core_cmd_data_o, state_lock_cmd_o, perf_cmd_cnt_o, perf_tmo_cnt_o}), 80'(0));
    tick();
    rst = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("t6_queue_discarded", 80'({core_cmd_valid_o, host_rsp_valid_o, state_lock_cmd_o}), 80'(0));
    check("t6_fsm_idle", 80'(dbg_state_o), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
